reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Board-level reset generator for the clock domain driving the signal pipeline. It qualifies PLL lock, debounces a push-button and accepts software reset requests. It drives NDOM active-low reset outputs that assert together and release in staged order, one per downstream domain. Each downstream domain re-synchronises its output locally.

Parameters:
NDOM, 3, number of reset outputs / domains released in order 0..NDOM-1
HOLD_CYCLES, 16, minimum cycles all outputs stay asserted after any reset event
STAGE_CYCLES, 8, cycles between release of output k-1 and output k
LOCK_FILTER, 4, consecutive synchronised pll_lock-high cycles required
DEBOUNCE_CYCLES, 1024, cycles button level must be stable to be accepted

Ports:
clock  input  1  free-running reference clock
arst_n  input  1  asynchronous active-low reset; clock clock
pll_lock  input  1  asynchronous PLL lock indicator
button_n  input  1  raw asynchronous push-button, low = pressed
sw_reset_req  input  1  single-cycle synchronous reset request pulse
rst_n_out  output  NDOM  registered active-low resets, bit k = domain k
done  output  1  high in RUN (all outputs released)
reset_cause  output  2  cause of last reset: 0 arst, 1 lock loss, 2 software, 3 button

Behaviour:
- arst_n low: all registers clear asynchronously; rst_n_out=0, done=0, reset_cause=0, state HOLD, counters 0, debounced button = released, sync flops 0.
- All outputs come directly from flops; no combinational paths to rst_n_out.
- pll_lock, button_n: 2-flop synchronisers, 2-cycle latency.
- Lock filter: saturating counter 0..LOCK_FILTER. Increments while lock_s=1, clears when lock_s=0. lock_ok = (count==LOCK_FILTER). Runs in every state.
- Debounce: counter increments while button_s differs from the debounced level and clears when equal. On reaching DEBOUNCE_CYCLES the debounced level flips and the counter clears. press_evt = debounced level transitions to pressed.
- States:
  - HOLD: rst_n_out=0. Count 0..HOLD_CYCLES-1, then go to WAIT_LOCK, so HOLD lasts exactly HOLD_CYCLES cycles. While the debounced button is pressed, or when sw_reset_req=1, the count resets to 0.
  - WAIT_LOCK: on the first edge where lock_ok=1, set rst_n_out[0]=1, stage counter=0, go to RELEASE.
  - RELEASE: the stage counter counts STAGE_CYCLES cycles, then sets the next output bit. On the same edge that sets bit NDOM-1: go to RUN, done=1. NDOM=1 goes straight from WAIT_LOCK to RUN.
  - RUN: hold outputs high.
- Abort (WAIT_LOCK, RELEASE, RUN):
  - Triggers: press_evt, sw_reset_req, or lock_s=0 (lock loss applies in RELEASE and RUN only).
  - Next edge: rst_n_out=0, done=0, state HOLD, counters 0, reset_cause latched.
- Simultaneous causes: priority button(3) > software(2) > lock(1).
- In HOLD, reset_cause updates on press_evt or sw_reset_req with the same priority.
- Counter widths: $clog2(max+1). No wrap; terminal compare uses ==.

Decomposition:
- Package reset_seq_pkg:
  - state enum (HOLD, WAIT_LOCK, RELEASE, RUN)
  - cause encodings CAUSE_ARST/LOCK/SW/BUTTON
  - width helper function
- Sub-module button_debounce: synchroniser, debounce counter, debounced level and press_evt output; clock/arst_n shared with the parent.

Test Plan:
(All with NDOM=3, HOLD=4, STAGE=3, LOCK_FILTER=2, DEBOUNCE=5.)
1. pll_lock=1 throughout, arst_n released before edge 1 -> rst_n_out: 001 after edge 5, 011 after edge 8, 111 after edge 11, done=1 after edge 11, reset_cause=0.
2. pll_lock=0 until edge 20, then 1 -> outputs stay 000, state WAIT_LOCK; bit0 releases 4 edges after pll_lock rises (2 sync + 2 filter).
3. In RUN, drop pll_lock for 1 cycle -> rst_n_out=000, done=0, 2 edges after the drop plus 1; reset_cause=1; then the full sequence repeats (HOLD 4 cycles).
4. In RELEASE, with rst_n_out=011, pulse sw_reset_req -> 000 next edge, reset_cause=2. Repeat with sw_reset_req and press_evt on the same cycle -> reset_cause=3.
5. Button bounce: low 3 cycles, high 2, low 3 -> no reset. Hold low 10 cycles -> press_evt after 2+5 cycles, outputs 000, cause=3. HOLD does not exit until the button is released and debounced, plus 4 cycles.
6. Assert arst_n mid-RELEASE, asynchronously between edges -> rst_n_out=000 and done=0 immediately, with no clock edge; reset_cause=0 after release.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the board reset sequencer: FSM states,
// reset-cause encodings and counter width sizing.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_ARST   = 2'd0,
        CAUSE_LOCK   = 2'd1,
        CAUSE_SW     = 2'd2,
        CAUSE_BUTTON = 2'd3
    } cause_e;

    // Bits needed for a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 32'sd1);
    endfunction

endpackage

// File: rtl/reset_sequencer_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press event when the accepted level changes to pressed.
module button_debounce
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clock,
    input  logic arst_n,
    input  logic button_n,
    output logic pressed,
    output logic press_evt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          btn_meta_q;
    logic          btn_sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_n_q;
    logic          level_n_d;
    logic          press_evt_q;
    logic          press_evt_d;

    // Synchroniser plus debounce state registers.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            cnt_q       <= '0;
            level_n_q   <= 1'b1;
            press_evt_q <= 1'b0;
        end else begin
            btn_meta_q  <= button_n;
            btn_sync_q  <= btn_meta_q;
            cnt_q       <= cnt_d;
            level_n_q   <= level_n_d;
            press_evt_q <= press_evt_d;
        end
    end

    // A new level is accepted only after it has differed for the full window.
    always_comb begin
        cnt_d       = cnt_q;
        level_n_d   = level_n_q;
        press_evt_d = 1'b0;
        if (btn_sync_q != level_n_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 32'sd1)) begin
                cnt_d       = '0;
                level_n_d   = btn_sync_q;
                press_evt_d = ~btn_sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1'b1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign pressed   = ~level_n_q;
    assign press_evt = press_evt_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset generator: qualifies PLL lock, debounced button and software
// requests, then releases NDOM active-low resets in staged order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NDOM            = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_CYCLES    = 8,
    parameter int LOCK_FILTER     = 4,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic            clock,
    input  logic            arst_n,
    input  logic            pll_lock,
    input  logic            button_n,
    input  logic            sw_reset_req,
    output logic [NDOM-1:0] rst_n_out,
    output logic            done,
    output logic [1:0]      reset_cause
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int SW = cnt_width(STAGE_CYCLES);
    localparam int LW = cnt_width(LOCK_FILTER);
    localparam logic [NDOM-1:0] FIRST_MASK = NDOM'(1'b1);

    state_e          state_q, state_d;
    cause_e          cause_q, cause_d, req_cause_s;
    logic [HW-1:0]   hold_q, hold_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NDOM-1:0] rst_q, rst_d, shift_mask_s;
    logic            done_q, done_d;
    logic            lock_meta_q, lock_s_q;
    logic            lock_ok_s, abort_s;
    logic            btn_pressed_s, press_evt_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock     (clock),
        .arst_n    (arst_n),
        .button_n  (button_n),
        .pressed   (btn_pressed_s),
        .press_evt (press_evt_s)
    );

    // Lock synchroniser, lock filter and sequencer state registers.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            lock_cnt_q  <= '0;
            state_q     <= ST_HOLD;
            cause_q     <= CAUSE_ARST;
            hold_q      <= '0;
            stage_q     <= '0;
            rst_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            lock_cnt_q  <= lock_cnt_d;
            state_q     <= state_d;
            cause_q     <= cause_d;
            hold_q      <= hold_d;
            stage_q     <= stage_d;
            rst_q       <= rst_d;
            done_q      <= done_d;
        end
    end

    // Saturating lock filter, active in every state.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!lock_s_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LW'(LOCK_FILTER)) begin
            lock_cnt_d = lock_cnt_q + LW'(1'b1);
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    assign lock_ok_s    = (lock_cnt_q == LW'(LOCK_FILTER));
    assign shift_mask_s = (rst_q << 1) | FIRST_MASK;

    // Abort qualification and cause priority: button > software > lock loss.
    always_comb begin
        abort_s     = 1'b0;
        req_cause_s = CAUSE_LOCK;
        if (press_evt_s) begin
            req_cause_s = CAUSE_BUTTON;
        end else if (sw_reset_req) begin
            req_cause_s = CAUSE_SW;
        end else begin
            req_cause_s = CAUSE_LOCK;
        end
        case (state_q)
            ST_WAIT_LOCK:        abort_s = press_evt_s | sw_reset_req;
            ST_RELEASE, ST_RUN:  abort_s = press_evt_s | sw_reset_req | ~lock_s_q;
            default:             abort_s = 1'b0;
        endcase
    end

    // Sequencer next-state and output logic.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        done_d  = done_q;
        if (abort_s) begin
            state_d = ST_HOLD;
            cause_d = req_cause_s;
            hold_d  = '0;
            stage_d = '0;
            rst_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rst_d  = '0;
                    done_d = 1'b0;
                    if (press_evt_s || sw_reset_req) begin
                        cause_d = req_cause_s;
                    end else begin
                        cause_d = cause_q;
                    end
                    if (btn_pressed_s || sw_reset_req) begin
                        hold_d = '0;
                    end else if (hold_q == HW'(HOLD_CYCLES - 32'sd1)) begin
                        hold_d  = '0;
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        hold_d = hold_q + HW'(1'b1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_ok_s) begin
                        rst_d   = FIRST_MASK;
                        stage_d = '0;
                        if (FIRST_MASK[NDOM-1]) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_RELEASE: begin
                    if (stage_q == SW'(STAGE_CYCLES - 32'sd1)) begin
                        stage_d = '0;
                        rst_d   = shift_mask_s;
                        if (shift_mask_s[NDOM-1]) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        stage_d = stage_q + SW'(1'b1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HOLD;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign rst_n_out   = rst_q;
    assign done        = done_q;
    assign reset_cause = cause_q;

endmodule
